// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key code width, special key codes and the
// active-low one-hot decoder used for both row drive and column sense.
package keypad_pkg;

  localparam int KEY_W = 4;

  typedef logic [KEY_W-1:0] keyCode_t;

  localparam keyCode_t KEY_STAR = 4'hC;
  localparam keyCode_t KEY_HASH = 4'hE;

  // Bit 3 carries line 0, so the index counts down from the MSB.
  function automatic void onehot0_idx(input logic [3:0] v,
                                      output logic valid,
                                      output logic [1:0] idx);
    valid = 1'b0;
    idx   = 2'd0;
    case (v)
      4'b0111: begin valid = 1'b1; idx = 2'd0; end
      4'b1011: begin valid = 1'b1; idx = 2'd1; end
      4'b1101: begin valid = 1'b1; idx = 2'd2; end
      4'b1110: begin valid = 1'b1; idx = 2'd3; end
      default: begin valid = 1'b0; idx = 2'd0; end
    endcase
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small first-word-fall-through FIFO for decoded key codes; the head reads
// as zero while empty so the output is defined straight out of reset.
module key_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr,
  input  logic [KEY_W-1:0] din,
  input  logic             rd,
  output logic [KEY_W-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      cnt
);

  logic [KEY_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doRd;
  logic             doWr;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside a read.
  assign doRd  = rd & ~empty;
  assign doWr  = wr & (~full | doRd);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doWr) wrPtr <= wrPtr + 1'b1;
      if (doRd) rdPtr <= rdPtr + 1'b1;
      case ({doWr, doRd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (doWr) mem[wrPtr] <= din;
  end

  assign dout = empty ? '0 : mem[rdPtr];

endmodule

// File: rtl/keypad_decoder.sv
// Keypad scan consumer: detects each new press, captures the row/column
// pattern, validates it and queues the resulting key index.
module keypad_decoder
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       R,
  input  logic [3:0]       C,
  input  logic             startSet,
  input  logic             key_rd,
  input  logic             clr_err,
  output logic [KEY_W-1:0] key_code,
  output logic             key_empty,
  output logic             key_full,
  output logic [AW:0]      key_cnt,
  output logic             bad_key,
  output logic             overflow
);

  logic       startQ;
  logic       press;
  logic [3:0] rowDrv_p1;
  logic [3:0] colSense_p1;
  logic       vld_p1;

  logic       rowOk;
  logic       colOk;
  logic [1:0] rowIdx;
  logic [1:0] colIdx;
  keyCode_t   code_p1;
  logic       keyOk;
  logic       pushKey;
  logic       dropKey;

  assign press = startSet & ~startQ;

  // Stage 1: capture the scan pattern on the rising edge of the press flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      startQ <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      startQ <= startSet;
      vld_p1 <= press;
    end
  end

  always_ff @(posedge CLK) begin
    if (press) begin
      rowDrv_p1   <= R;
      colSense_p1 <= C;
    end
  end

  // Stage 2: validate and decode, then push or drop
  always_comb begin
    rowOk   = 1'b0;
    colOk   = 1'b0;
    rowIdx  = 2'd0;
    colIdx  = 2'd0;
    onehot0_idx(rowDrv_p1, rowOk, rowIdx);
    onehot0_idx(colSense_p1, colOk, colIdx);
    code_p1 = {rowIdx, colIdx};
    keyOk   = vld_p1 & rowOk & colOk;
    pushKey = keyOk & (~key_full | key_rd);
    dropKey = keyOk & ~pushKey;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bad_key  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      bad_key <= vld_p1 & ~(rowOk & colOk);
      if (dropKey)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
    end
  end

  key_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .CLK  (CLK),
    .RST  (RST),
    .wr   (pushKey),
    .din  (code_p1),
    .rd   (key_rd),
    .dout (key_code),
    .empty(key_empty),
    .full (key_full),
    .cnt  (key_cnt)
  );

endmodule

// File: tb/tb_keypad_decoder.sv
// Bench for keypad_decoder: directed scenarios plus random traffic, all
// compared every cycle against a queue-based model of the key path.
module tb_keypad_decoder;
  import keypad_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic [3:0]    R;
  logic [3:0]    C;
  logic          startSet;
  logic          key_rd;
  logic          clr_err;
  logic [3:0]    key_code;
  logic          key_empty;
  logic          key_full;
  logic [AW:0]   key_cnt;
  logic          bad_key;
  logic          overflow;

  int nCompared   = 0;
  int nMismatched = 0;

  int q[$];
  bit mOvf    = 1'b0;
  bit mBad    = 1'b0;
  bit mStartQ = 1'b0;
  bit pendV   = 1'b0;
  bit pendOk  = 1'b0;
  int pendCode = 0;

  keypad_decoder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .R        (R),
    .C        (C),
    .startSet (startSet),
    .key_rd   (key_rd),
    .clr_err  (clr_err),
    .key_code (key_code),
    .key_empty(key_empty),
    .key_full (key_full),
    .key_cnt  (key_cnt),
    .bad_key  (bad_key),
    .overflow (overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count the low lines; a key is legal only with exactly one low row and one low column.
  function automatic void decode(input logic [3:0] r, input logic [3:0] c,
                                 output bit ok, output int code);
    int rz = 0;
    int cz = 0;
    int row = 0;
    int col = 0;
    for (int i = 0; i < 4; i++) begin
      if (r[i] == 1'b0) begin rz++; row = 3 - i; end
      if (c[i] == 1'b0) begin cz++; col = 3 - i; end
    end
    ok   = (rz == 1) && (cz == 1);
    code = row * 4 + col;
  endfunction

  function automatic logic [3:0] lineOf(input int idx);
    logic [3:0] one = 4'b1000;
    return ~(one >> idx);
  endfunction

  // Advance the model by one clock edge using the current inputs, then clock the DUT and compare.
  task automatic step();
    bit popped;
    bit dropped;
    if (RST) begin
      q.delete();
      mOvf    = 1'b0;
      mBad    = 1'b0;
      pendV   = 1'b0;
      mStartQ = 1'b0;
    end else begin
      popped  = key_rd && (q.size() > 0);
      dropped = 1'b0;
      if (popped) void'(q.pop_front());
      mBad = pendV && !pendOk;
      if (pendV && pendOk) begin
        if (q.size() < DEPTH) q.push_back(pendCode);
        else dropped = 1'b1;
      end
      if (dropped)      mOvf = 1'b1;
      else if (clr_err) mOvf = 1'b0;
      pendV = startSet && !mStartQ;
      if (pendV) decode(R, C, pendOk, pendCode);
      mStartQ = startSet;
    end
    @(posedge CLK);
    #1;
    check("key_empty", key_empty, q.size() == 0);
    check("key_full",  key_full,  q.size() == DEPTH);
    check("key_cnt",   key_cnt,   q.size());
    check("bad_key",   bad_key,   mBad);
    check("overflow",  overflow,  mOvf);
    if (q.size() > 0) check("key_code", key_code, q[0]);
  endtask

  task automatic setKey(input int code);
    R = lineOf(code / 4);
    C = lineOf(code % 4);
  endtask

  task automatic pressKey(input int code);
    setKey(code);
    startSet = 1'b1;
    step();
    step();
    startSet = 1'b0;
    step();
  endtask

  task automatic popKey(input int expCode);
    check("pop_head", key_code, expCode);
    key_rd = 1'b1;
    step();
    key_rd = 1'b0;
  endtask

  initial begin
    RST = 1'b1; R = 4'hF; C = 4'hF; startSet = 1'b0; key_rd = 1'b0; clr_err = 1'b0;
    step();
    step();
    check("rst_code", key_code, 4'h0);
    check("rst_empty", key_empty, 1'b1);
    RST = 1'b0;
    step();

    // Single held press yields exactly one entry
    R = 4'b1011; C = 4'b1101; startSet = 1'b1;
    step();
    check("t1_empty_k", key_empty, 1'b1);
    step();
    check("t1_empty_k1", key_empty, 1'b0);
    check("t1_code", key_code, 4'h6);
    repeat (48) step();
    startSet = 1'b0;
    step();
    check("t1_cnt", key_cnt, 1);
    popKey(6);

    // Fill, overflow on the fifth press, drain in order
    pressKey(1); pressKey(2); pressKey(3); pressKey(4); pressKey(15);
    check("t2_full", key_full, 1'b1);
    check("t2_ovf", overflow, 1'b1);
    for (int i = 1; i <= 4; i++) popKey(i);
    check("t2_empty", key_empty, 1'b1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t2_clr", overflow, 1'b0);

    // Ghost and no-column patterns pulse bad_key for one cycle
    pressKey(5);
    for (int t = 0; t < 2; t++) begin
      R = 4'b1011;
      C = (t == 0) ? 4'b1001 : 4'b1111;
      startSet = 1'b1;
      step();
      step();
      check("t3_bad_hi", bad_key, 1'b1);
      step();
      check("t3_bad_lo", bad_key, 1'b0);
      check("t3_cnt", key_cnt, 1);
      startSet = 1'b0;
      step();
    end

    // Push while full with a simultaneous pop
    pressKey(7); pressKey(8); pressKey(9);
    check("t4_full", key_full, 1'b1);
    setKey(10);
    startSet = 1'b1;
    step();
    key_rd = 1'b1;
    step();
    key_rd = 1'b0;
    check("t4_cnt", key_cnt, 4);
    check("t4_ovf", overflow, 1'b0);
    startSet = 1'b0;
    step();
    popKey(7); popKey(8); popKey(9); popKey(10);

    // Reset mid-press re-arms the edge detector
    pressKey(1); pressKey(2);
    setKey(3);
    startSet = 1'b1;
    step();
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t5_empty", key_empty, 1'b1);
    check("t5_ovf", overflow, 1'b0);
    check("t5_code", key_code, 4'h0);
    step();
    step();
    check("t5_cnt", key_cnt, 1);
    check("t5_code2", key_code, 4'h3);
    startSet = 1'b0;
    step();
    popKey(3);

    // Pops on an empty FIFO are ignored
    key_rd = 1'b1;
    repeat (3) step();
    key_rd = 1'b0;
    check("t6_cnt0", key_cnt, 0);
    R = 4'b0111; C = 4'b0111; startSet = 1'b1;
    step(); step();
    startSet = 1'b0;
    step();
    check("t6_code", key_code, 4'h0);
    check("t6_cnt1", key_cnt, 1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      RST = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) == 0) startSet = ~startSet;
      if ($urandom_range(0, 3) != 0) setKey($urandom_range(0, 15));
      else begin
        R = 4'($urandom);
        C = 4'($urandom);
      end
      key_rd  = ($urandom_range(0, 2) == 0);
      clr_err = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
